// File: rtl/axi4lite_arbiter_pkg.sv
// axi4lite_arbiter_pkg: shared AXI4-Lite channel structs and arbiter enums (package axi4lite_parameters)
package axi4lite_parameters;
   localparam int AXI4LITE_ADDR_W = 32;
   localparam int AXI4LITE_DATA_W = 32;
   typedef struct packed {
      logic                         awvalid;
      logic [AXI4LITE_ADDR_W-1:0]   awaddr;
      logic                         wvalid;
      logic [AXI4LITE_DATA_W-1:0]   wdata;
      logic [AXI4LITE_DATA_W/8-1:0] wstrb;
      logic                         bready;
      logic                         arvalid;
      logic [AXI4LITE_ADDR_W-1:0]   araddr;
      logic                         rready;
   } type_axi4lite_master2slave_s;
   typedef struct packed {
      logic                       awready;
      logic                       wready;
      logic                       bvalid;
      logic [1:0]                 bresp;
      logic                       arready;
      logic                       rvalid;
      logic [AXI4LITE_DATA_W-1:0] rdata;
      logic [1:0]                 rresp;
   } type_axi4lite_slave2master_s;
   typedef enum logic [1:0] {IDLE, WRITE, READ} type_axi4lite_arb_state_e;
   typedef enum logic {KIND_WRITE, KIND_READ} type_axi4lite_arb_kind_e;
endpackage

// File: rtl/axi4lite_arbiter_picker.sv
// rr_priority_picker: one-hot grant search from last+1 (AXI4LITE_ARB_ROUND_ROBIN_EN) or lowest index
module rr_priority_picker #(
   parameter int N  = 2,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  req,
`ifdef AXI4LITE_ARB_ROUND_ROBIN_EN
   input  logic [LW-1:0] last,
`endif
   output logic [N-1:0]  grant,
   output logic [LW-1:0] winner
);
   // scan from the farthest candidate inward so the nearest requester overwrites
   always_comb begin
      int idx;
      idx    = 0;
      grant  = '0;
      winner = '0;
      for (int k = N - 1; k >= 0; k--) begin
`ifdef AXI4LITE_ARB_ROUND_ROBIN_EN
         idx = (int'(last) + 1 + k) % N;
`else
         idx = k;
`endif
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            winner     = idx[LW-1:0];
         end
      end
   end
endmodule

// File: rtl/axi4lite_arbiter.sv
// axi4lite_arbiter: shares one AXI4-Lite slave among masters, one whole transaction per grant; AXI4LITE_ARB_ROUND_ROBIN_EN selects round-robin
module axi4lite_arbiter
   import axi4lite_parameters::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  type_axi4lite_master2slave_s m2arb [NUM_MASTERS],
   output type_axi4lite_slave2master_s arb2m [NUM_MASTERS],
   output type_axi4lite_master2slave_s arb2s,
   input  type_axi4lite_slave2master_s s2arb
);
   localparam int LW = $clog2(NUM_MASTERS);
   type_axi4lite_arb_state_e    state;
   type_axi4lite_arb_kind_e     kind;
   type_axi4lite_master2slave_s sel;
   logic [LW-1:0]               owner, winner;
   logic [NUM_MASTERS-1:0]      wreq, rreq, req, grant;
   logic                        win_w, wr_on, rd_on;
`ifdef AXI4LITE_ARB_ROUND_ROBIN_EN
   logic [LW-1:0]               last;
`endif
   // per-master request terms
   always_comb begin
      wreq = '0;
      rreq = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         wreq[i] = m2arb[i].awvalid | m2arb[i].wvalid;
         rreq[i] = m2arb[i].arvalid;
      end
   end
   assign req   = wreq | rreq;
   assign win_w = |(grant & wreq);
   assign wr_on = (state == WRITE) && (kind == KIND_WRITE);
   assign rd_on = (state == READ) && (kind == KIND_READ);
   rr_priority_picker #(.N(NUM_MASTERS)) u_picker (
      .req    (req),
`ifdef AXI4LITE_ARB_ROUND_ROBIN_EN
      .last   (last),
`endif
      .grant  (grant),
      .winner (winner)
   );
   // grant FSM: lock owner until its response handshake, write before read within a master
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         kind  <= KIND_WRITE;
         owner <= '0;
`ifdef AXI4LITE_ARB_ROUND_ROBIN_EN
         last  <= LW'(NUM_MASTERS - 1);
`endif
      end else begin
         case (state)
            IDLE: if (|req) begin
               owner <= winner;
               kind  <= win_w ? KIND_WRITE : KIND_READ;
               state <= win_w ? WRITE : READ;
`ifdef AXI4LITE_ARB_ROUND_ROBIN_EN
               last  <= winner;
`endif
            end
            WRITE: if (s2arb.bvalid && m2arb[owner].bready) state <= IDLE;
            READ:  if (s2arb.rvalid && m2arb[owner].rready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   // channel mux: only the owner's active channel passes, everything else reads as zero
   always_comb begin
      sel   = m2arb[owner];
      arb2s = '0;
      for (int j = 0; j < NUM_MASTERS; j++) arb2m[j] = '0;
      if (wr_on) begin
         arb2s.awvalid         = sel.awvalid;
         arb2s.awaddr          = sel.awaddr;
         arb2s.wvalid          = sel.wvalid;
         arb2s.wdata           = sel.wdata;
         arb2s.wstrb           = sel.wstrb;
         arb2s.bready          = sel.bready;
         arb2m[owner].awready  = s2arb.awready;
         arb2m[owner].wready   = s2arb.wready;
         arb2m[owner].bvalid   = s2arb.bvalid;
         arb2m[owner].bresp    = s2arb.bresp;
      end
      if (rd_on) begin
         arb2s.arvalid         = sel.arvalid;
         arb2s.araddr          = sel.araddr;
         arb2s.rready          = sel.rready;
         arb2m[owner].arready  = s2arb.arready;
         arb2m[owner].rvalid   = s2arb.rvalid;
         arb2m[owner].rdata    = s2arb.rdata;
         arb2m[owner].rresp    = s2arb.rresp;
      end
   end
endmodule

// File: tb/tb_axi4lite_arbiter.sv
// tb_axi4lite_arbiter: directed bench with two master models and a stallable memory slave
module tb_axi4lite_arbiter;
   import axi4lite_parameters::*;
   localparam int N = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   type_axi4lite_master2slave_s m2arb [N];
   type_axi4lite_slave2master_s arb2m [N];
   type_axi4lite_master2slave_s arb2s;
   type_axi4lite_slave2master_s s2arb;
   int wgo [N] = '{0, 0};
   int rgo [N] = '{0, 0};
   int wld [N] = '{0, 0};
   int rld [N] = '{0, 0};
   int wack [N] = '{0, 0};
   int rack [N] = '{0, 0};
   bit rep [N] = '{1'b0, 1'b0};
   logic [31:0] cwa [N];
   logic [31:0] cwd [N];
   logic [31:0] cra [N];
   logic [31:0] rgot [N];
   logic [31:0] mem [256];
   logic [31:0] ra;
   int lg [256];
   int ln = 0;
   int stall_w = 0, stall_r = 0, wcnt = 0, rcnt = 0;
   logic rwait;
   int n_cmp = 0, n_bad = 0;
`ifdef AXI4LITE_ARB_ROUND_ROBIN_EN
   int exp_pair [2] = '{21, 20};
   int exp_cont [6] = '{20, 21, 20, 21, 20, 21};
`else
   int exp_pair [2] = '{20, 21};
   int exp_cont [6] = '{20, 20, 20, 20, 20, 20};
`endif

   always #5 clk = ~clk;

   axi4lite_arbiter #(.NUM_MASTERS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .m2arb (m2arb),
      .arb2m (arb2m),
      .arb2s (arb2s),
      .s2arb (s2arb)
   );

   // master models plus a memory slave with programmable write-ready and read-data stalls
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m2arb[i] <= '0;
            wld[i]   <= wgo[i];
            rld[i]   <= rgo[i];
         end
         s2arb <= '0;
         wcnt  <= 0;
         rcnt  <= 0;
         rwait <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m2arb[i].awvalid && arb2m[i].awready) m2arb[i].awvalid <= 1'b0;
            if (m2arb[i].wvalid && arb2m[i].wready) m2arb[i].wvalid <= 1'b0;
            if (m2arb[i].bready && arb2m[i].bvalid) begin
               m2arb[i].bready <= 1'b0;
               wack[i]         <= wack[i] + 1;
               lg[ln & 255]    <= 10 + i;
               ln              <= ln + 1;
            end
            if (m2arb[i].arvalid && arb2m[i].arready) m2arb[i].arvalid <= 1'b0;
            if (m2arb[i].rready && arb2m[i].rvalid) begin
               rgot[i]          <= arb2m[i].rdata;
               rack[i]          <= rack[i] + 1;
               lg[ln & 255]     <= 20 + i;
               ln               <= ln + 1;
               m2arb[i].arvalid <= rep[i];
               m2arb[i].rready  <= rep[i];
            end
            if (wgo[i] != wld[i]) begin
               m2arb[i].awvalid <= 1'b1;
               m2arb[i].awaddr  <= cwa[i];
               m2arb[i].wvalid  <= 1'b1;
               m2arb[i].wdata   <= cwd[i];
               m2arb[i].wstrb   <= 4'hf;
               m2arb[i].bready  <= 1'b1;
               wld[i]           <= wgo[i];
            end
            if (rgo[i] != rld[i]) begin
               m2arb[i].arvalid <= 1'b1;
               m2arb[i].araddr  <= cra[i];
               m2arb[i].rready  <= 1'b1;
               rld[i]           <= rgo[i];
            end
         end
         if (s2arb.awready) begin
            s2arb.awready <= 1'b0;
            s2arb.wready  <= 1'b0;
            s2arb.bvalid  <= 1'b1;
            s2arb.bresp   <= 2'b00;
            mem[arb2s.awaddr[9:2]] <= arb2s.wdata;
            wcnt <= 0;
         end else if (arb2s.awvalid && arb2s.wvalid && !s2arb.bvalid) begin
            if (wcnt >= stall_w) begin
               s2arb.awready <= 1'b1;
               s2arb.wready  <= 1'b1;
            end else wcnt <= wcnt + 1;
         end
         if (s2arb.bvalid && arb2s.bready) s2arb.bvalid <= 1'b0;
         if (s2arb.rvalid && arb2s.rready) s2arb.rvalid <= 1'b0;
         if (s2arb.arready) begin
            s2arb.arready <= 1'b0;
            ra            <= arb2s.araddr;
            rwait         <= 1'b1;
            rcnt          <= 0;
         end else if (rwait) begin
            if (rcnt >= stall_r) begin
               s2arb.rvalid <= 1'b1;
               s2arb.rdata  <= mem[ra[9:2]];
               s2arb.rresp  <= 2'b00;
               rwait        <= 1'b0;
            end else rcnt <= rcnt + 1;
         end else if (arb2s.arvalid && !s2arb.rvalid) s2arb.arready <= 1'b1;
      end
   end

   task automatic issue_write(input int i, input logic [31:0] a, input logic [31:0] d);
      cwa[i] = a;
      cwd[i] = d;
      wgo[i] = wgo[i] + 1;
   endtask

   task automatic issue_read(input int i, input logic [31:0] a);
      cra[i] = a;
      rgo[i] = rgo[i] + 1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      stall_w = 0;
      stall_r = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (arb2s !== '0) begin n_bad++; $display("FAIL reset_arb2s got %h want 0", arb2s); end
      n_cmp++; if (arb2m[0] !== '0) begin n_bad++; $display("FAIL reset_arb2m0 got %h want 0", arb2m[0]); end
      n_cmp++; if (arb2m[1] !== '0) begin n_bad++; $display("FAIL reset_arb2m1 got %h want 0", arb2m[1]); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (arb2s !== '0) begin n_bad++; $display("FAIL post_reset_idle got %h want 0", arb2s); end
   endtask

   task automatic test_single_write();
      int w0, r0;
      w0 = wack[0];
      r0 = rack[0];
      issue_write(0, 32'h40, 32'hDEAD_BEEF);
      @(negedge clk);
      n_cmp++; if (arb2s.awvalid !== 1'b0) begin n_bad++; $display("FAIL sw_req_cycle awvalid got %b want 0", arb2s.awvalid); end
      @(negedge clk);
      n_cmp++; if (arb2s.awvalid !== 1'b1) begin n_bad++; $display("FAIL sw_grant awvalid got %b want 1", arb2s.awvalid); end
      n_cmp++; if (arb2s.awaddr !== 32'h40) begin n_bad++; $display("FAIL sw_awaddr got %h want 40", arb2s.awaddr); end
      n_cmp++; if (arb2s.wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_wdata got %h want deadbeef", arb2s.wdata); end
      for (int k = 0; k < 60 && wack[0] == w0; k++) @(negedge clk);
      n_cmp++; if (wack[0] != w0 + 1) begin n_bad++; $display("FAIL sw_bresp got %0d want %0d", wack[0], w0 + 1); end
      n_cmp++; if (arb2s !== '0) begin n_bad++; $display("FAIL sw_back_idle got %h want 0", arb2s); end
      issue_read(0, 32'h40);
      for (int k = 0; k < 60 && rack[0] == r0; k++) @(negedge clk);
      n_cmp++; if (rgot[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_readback got %h want deadbeef", rgot[0]); end
   endtask

   task automatic test_contention();
      int l0, r0;
      apply_reset();
      l0 = ln;
      r0 = rack[0];
      issue_read(0, 32'h40);
      issue_read(1, 32'h44);
      repeat (2) @(negedge clk);
      n_cmp++; if (arb2s.araddr !== 32'h40) begin n_bad++; $display("FAIL ct_first_grant araddr got %h want 40", arb2s.araddr); end
      for (int k = 0; k < 60 && rack[0] == r0; k++) begin
         n_cmp++; if (arb2m[1] !== '0) begin n_bad++; $display("FAIL ct_loser_masked got %h want 0", arb2m[1]); end
         @(negedge clk);
      end
      for (int k = 0; k < 60 && ln < l0 + 2; k++) @(negedge clk);
      n_cmp++; if (lg[l0 & 255] != 20) begin n_bad++; $display("FAIL ct_order0 got %0d want 20", lg[l0 & 255]); end
      n_cmp++; if (lg[(l0 + 1) & 255] != 21) begin n_bad++; $display("FAIL ct_order1 got %0d want 21", lg[(l0 + 1) & 255]); end
      l0 = ln;
      issue_read(0, 32'h40);
      for (int k = 0; k < 60 && ln < l0 + 1; k++) @(negedge clk);
      n_cmp++; if (lg[l0 & 255] != 20) begin n_bad++; $display("FAIL ct_solo got %0d want 20", lg[l0 & 255]); end
      l0 = ln;
      issue_read(0, 32'h40);
      issue_read(1, 32'h44);
      for (int k = 0; k < 60 && ln < l0 + 2; k++) @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         n_cmp++; if (lg[(l0 + p) & 255] != exp_pair[p]) begin n_bad++; $display("FAIL ct_pair%0d got %0d want %0d", p, lg[(l0 + p) & 255], exp_pair[p]); end
      end
   endtask

   task automatic test_continuous();
      int l0;
      apply_reset();
      l0 = ln;
      rep[0] = 1'b1;
      rep[1] = 1'b1;
      issue_read(0, 32'h40);
      issue_read(1, 32'h44);
      for (int k = 0; k < 200 && ln < l0 + 6; k++) @(negedge clk);
      rep[0] = 1'b0;
      rep[1] = 1'b0;
      for (int p = 0; p < 6; p++) begin
         n_cmp++; if (lg[(l0 + p) & 255] != exp_cont[p]) begin n_bad++; $display("FAIL cont_grant%0d got %0d want %0d", p, lg[(l0 + p) & 255], exp_cont[p]); end
      end
      for (int k = 0; k < 200 && (m2arb[0].arvalid || m2arb[0].rready || m2arb[1].arvalid || m2arb[1].rready); k++) @(negedge clk);
      n_cmp++; if (m2arb[0].rready || m2arb[1].rready) begin n_bad++; $display("FAIL cont_drain got %b%b want 00", m2arb[0].rready, m2arb[1].rready); end
   endtask

   task automatic test_write_over_read();
      int w1, r1;
      apply_reset();
      w1 = wack[1];
      r1 = rack[1];
      issue_write(1, 32'h48, 32'hCAFE_F00D);
      issue_read(1, 32'h48);
      repeat (2) @(negedge clk);
      n_cmp++; if (arb2s.awvalid !== 1'b1) begin n_bad++; $display("FAIL wor_write_first got %b want 1", arb2s.awvalid); end
      n_cmp++; if (arb2s.arvalid !== 1'b0) begin n_bad++; $display("FAIL wor_ar_masked got %b want 0", arb2s.arvalid); end
      for (int k = 0; k < 60 && wack[1] == w1; k++) @(negedge clk);
      n_cmp++; if (arb2s !== '0) begin n_bad++; $display("FAIL wor_idle_gap got %h want 0", arb2s); end
      n_cmp++; if (rack[1] != r1) begin n_bad++; $display("FAIL wor_read_early got %0d want %0d", rack[1], r1); end
      @(negedge clk);
      n_cmp++; if (arb2s.arvalid !== 1'b1) begin n_bad++; $display("FAIL wor_read_grant got %b want 1", arb2s.arvalid); end
      n_cmp++; if (arb2s.awvalid !== 1'b0) begin n_bad++; $display("FAIL wor_aw_masked got %b want 0", arb2s.awvalid); end
      for (int k = 0; k < 60 && rack[1] == r1; k++) @(negedge clk);
      n_cmp++; if (rgot[1] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wor_rdata got %h want cafef00d", rgot[1]); end
   endtask

   task automatic test_reset_mid_read();
      int l0;
      apply_reset();
      stall_r = 20;
      issue_read(1, 32'h44);
      for (int k = 0; k < 60 && ln < 1; k++) @(negedge clk);
      l0 = ln;
      issue_read(0, 32'h40);
      for (int k = 0; k < 60 && ln < l0 + 1; k++) @(negedge clk);
      l0 = ln;
      issue_read(0, 32'h40);
      repeat (5) @(negedge clk);
      n_cmp++; if (arb2s.rready !== 1'b1) begin n_bad++; $display("FAIL rmr_in_read got %b want 1", arb2s.rready); end
      reset = 1'b1;
      #1;
      n_cmp++; if (arb2s !== '0) begin n_bad++; $display("FAIL rmr_arb2s got %h want 0", arb2s); end
      n_cmp++; if (arb2m[0] !== '0) begin n_bad++; $display("FAIL rmr_arb2m0 got %h want 0", arb2m[0]); end
      n_cmp++; if (arb2m[1] !== '0) begin n_bad++; $display("FAIL rmr_arb2m1 got %h want 0", arb2m[1]); end
      @(negedge clk);
      reset   = 1'b0;
      stall_r = 0;
      l0 = ln;
      issue_read(0, 32'h40);
      issue_read(1, 32'h44);
      repeat (2) @(negedge clk);
      n_cmp++; if (arb2s.araddr !== 32'h40) begin n_bad++; $display("FAIL rmr_m0_first got %h want 40", arb2s.araddr); end
      for (int k = 0; k < 60 && ln < l0 + 2; k++) @(negedge clk);
      n_cmp++; if (lg[l0 & 255] != 20) begin n_bad++; $display("FAIL rmr_order got %0d want 20", lg[l0 & 255]); end
   endtask

   task automatic test_backpressure();
      int w0, r0, r1;
      apply_reset();
      stall_w = 5;
      stall_r = 3;
      w0 = wack[0];
      r0 = rack[0];
      r1 = rack[1];
      issue_write(0, 32'h80, 32'h1234_5678);
      issue_read(1, 32'h40);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 60 && wack[0] == w0; k++) begin
         n_cmp++; if (arb2m[1] !== '0) begin n_bad++; $display("FAIL bp_w_loser got %h want 0", arb2m[1]); end
         n_cmp++; if (arb2s.awaddr !== 32'h80) begin n_bad++; $display("FAIL bp_w_locked got %h want 80", arb2s.awaddr); end
         @(negedge clk);
      end
      n_cmp++; if (rack[1] != r1) begin n_bad++; $display("FAIL bp_no_early_read got %0d want %0d", rack[1], r1); end
      for (int k = 0; k < 60 && rack[1] == r1; k++) begin
         n_cmp++; if (arb2m[0] !== '0) begin n_bad++; $display("FAIL bp_r_loser got %h want 0", arb2m[0]); end
         @(negedge clk);
      end
      n_cmp++; if (rgot[1] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bp_m1_rdata got %h want deadbeef", rgot[1]); end
      issue_read(0, 32'h80);
      for (int k = 0; k < 60 && rack[0] == r0; k++) @(negedge clk);
      n_cmp++; if (rgot[0] !== 32'h1234_5678) begin n_bad++; $display("FAIL bp_m0_rdata got %h want 12345678", rgot[0]); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_continuous();
      test_write_over_read();
      test_reset_mid_read();
      test_backpressure();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
